// File: rtl/board_pkg.sv
// ============================================================================
// board_pkg : shared board geometry, cell codes and arbiter state types
// Revision  : 1.0
// ============================================================================
`default_nettype none

package board_pkg;

    localparam int BOARD_W     = 40;
    localparam int BOARD_H     = 30;
    localparam int BOARD_CELLS = BOARD_W * BOARD_H;
    localparam int CELL_PX     = 16;
    localparam int ADDR_W      = 11;
    localparam int DATA_W      = 2;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BODY  = 2'd1,
        HEAD  = 2'd2,
        FOOD  = 2'd3
    } cell_t;

    typedef enum logic [0:0] {
        SERVE = 1'b0,
        CLEAR = 1'b1
    } arb_state_t;

    // Tag riding alongside each issued read so the two valids never cross
    typedef struct packed {
        logic disp;
        logic gm;
    } rd_tag_t;

endpackage

`default_nettype wire

// File: rtl/board_clear_seq.sv
// ============================================================================
// board_clear_seq : clear-sweep address counter with pause and last-cell flag
// Revision        : 1.0
// ============================================================================
`default_nettype none

module board_clear_seq #(
    parameter int ADDR_W      = 11,
    parameter int BOARD_CELLS = 1200
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_run,
    input  logic              i_pause,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_last
);
    import board_pkg::*;

    logic [ADDR_W-1:0] r_addr;
    logic              w_step;

    assign w_step = i_run & ~i_pause;
    assign o_last = w_step && (r_addr == ADDR_W'(BOARD_CELLS - 1));
    assign o_addr = r_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
        end else if (w_step) begin
            r_addr <= o_last ? '0 : r_addr + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/board_mem_arbiter.sv
// ============================================================================
// board_mem_arbiter : board RAM sharing between display, clear engine and game
//                     logic. Optional macro BOARD_ARB_WRFWD_EN: write forwarding.
// Revision          : 1.0
// ============================================================================
`default_nettype none

module board_mem_arbiter #(
    parameter int                   ADDR_W      = board_pkg::ADDR_W,
    parameter int                   DATA_W      = board_pkg::DATA_W,
    parameter int                   BOARD_CELLS = board_pkg::BOARD_CELLS,
    parameter logic [DATA_W-1:0]    CLEAR_VAL   = '0,
    parameter int                   WAIT_W      = 8
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              disp_valid,
    input  logic              gm_req,
    input  logic              gm_we,
    input  logic [ADDR_W-1:0] gm_addr,
    input  logic [DATA_W-1:0] gm_wdata,
    output logic              gm_ack,
    output logic [DATA_W-1:0] gm_rdata,
    output logic              gm_rvalid,
    input  logic              clear_start,
    output logic              clear_busy,
    output logic              clear_done,
    output logic [WAIT_W-1:0] gm_wait_max,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    import board_pkg::*;

    arb_state_t        r_state;
    arb_state_t        w_state_nxt;
    logic              w_clr_run;
    logic              w_clr_last;
    logic              w_clr_go;
    logic              w_gm_go;
    logic [ADDR_W-1:0] w_clr_addr;
    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] r_wait_max;
    rd_tag_t           r_tag1;
    rd_tag_t           r_tag2;
    logic              r_clr_done;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] w_rd_data;

    assign w_clr_run = (r_state == CLEAR);

    board_clear_seq #(
        .ADDR_W      (ADDR_W),
        .BOARD_CELLS (BOARD_CELLS)
    ) u_clear_seq (
        .clk     (Clk),
        .rst     (Reset),
        .i_run   (w_clr_run),
        .i_pause (disp_req),
        .o_addr  (w_clr_addr),
        .o_last  (w_clr_last)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_clr_go    = 1'b0;
        w_gm_go     = 1'b0;
        case (r_state)
            SERVE: begin
                w_gm_go = gm_req & ~disp_req & ~clear_start;
                if (clear_start) w_state_nxt = CLEAR;
            end
            CLEAR: begin
                w_clr_go = ~disp_req;
                if (w_clr_last) w_state_nxt = SERVE;
            end
            default: w_state_nxt = SERVE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state     <= SERVE;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_tag1      <= '0;
            r_tag2      <= '0;
            r_clr_done  <= 1'b0;
            r_wait      <= '0;
            r_wait_max  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_clr_done <= w_clr_last;
            r_tag2     <= r_tag1;
            r_tag1     <= '0;
            r_mem_we   <= 1'b0;
            // Display first, then the sweep, then the game port
            if (disp_req) begin
                r_mem_addr  <= disp_addr;
                r_tag1.disp <= 1'b1;
            end else if (w_clr_go) begin
                r_mem_addr  <= w_clr_addr;
                r_mem_we    <= 1'b1;
                r_mem_wdata <= CLEAR_VAL;
            end else if (w_gm_go) begin
                r_mem_addr  <= gm_addr;
                r_mem_we    <= gm_we;
                r_mem_wdata <= gm_wdata;
                r_tag1.gm   <= ~gm_we;
            end

            if (!gm_req || w_gm_go) begin
                r_wait <= '0;
            end else if (r_wait != '1) begin
                r_wait <= r_wait + 1'b1;
            end
            if (r_wait > r_wait_max) r_wait_max <= r_wait;
        end
    end

`ifdef BOARD_ARB_WRFWD_EN
    logic              r_fwd1;
    logic              r_fwd2;
    logic [DATA_W-1:0] r_fwd_data1;
    logic [DATA_W-1:0] r_fwd_data2;
    logic              w_rd_issue;
    logic [ADDR_W-1:0] w_rd_addr;

    assign w_rd_addr  = disp_req ? disp_addr : gm_addr;
    assign w_rd_issue = disp_req | (w_gm_go & ~gm_we);

    // A read issued right behind a write to the same cell takes the write data
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_fwd1      <= 1'b0;
            r_fwd2      <= 1'b0;
            r_fwd_data1 <= '0;
            r_fwd_data2 <= '0;
        end else begin
            r_fwd1      <= w_rd_issue & r_mem_we & (r_mem_addr == w_rd_addr);
            r_fwd_data1 <= r_mem_wdata;
            r_fwd2      <= r_fwd1;
            r_fwd_data2 <= r_fwd_data1;
        end
    end

    assign w_rd_data = r_fwd2 ? r_fwd_data2 : mem_rdata;
`else
    assign w_rd_data = mem_rdata;
`endif

    assign gm_ack      = w_gm_go & ~Reset;
    assign disp_valid  = r_tag2.disp;
    assign disp_rdata  = r_tag2.disp ? w_rd_data : '0;
    assign gm_rvalid   = r_tag2.gm;
    assign gm_rdata    = r_tag2.gm ? w_rd_data : '0;
    assign clear_busy  = w_clr_run;
    assign clear_done  = r_clr_done;
    assign gm_wait_max = r_wait_max;
    assign mem_addr    = r_mem_addr;
    assign mem_we      = r_mem_we;
    assign mem_wdata   = r_mem_wdata;

endmodule

`default_nettype wire
